uart_tx_fifo: RTL and testbench

- Parametrised next-generation UART transmitter with an input FIFO, runtime baud divisor, optional parity and configurable stop bits.
- Accepts bytes (or DATA_BITS words) on a valid/ready handshake, buffers them, and serialises back-to-back frames LSB-first on out.
- Sits between packet/loopback logic and the board TX pin.
- Each start bit is full-width: the baud counter restarts at frame start, so no free-running sync phase is needed.

---
 rtl/uart_tx_fifo.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, runtime baud divisor, optional parity and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input and the BREAK/BRKSTOP states.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
`ifdef UART_TX_BREAK_EN
  input  logic                          send_break,
`endif
  output logic                          out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PAR    = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd5;
  localparam logic [2:0] S_BRKSTP = 3'd6;
  localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int BRK_BITS   = 2 * FRAME_BITS;
  localparam int KW         = $clog2(BRK_BITS);
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        count_q, count_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 out_q, out_d;
  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
`ifdef UART_TX_BREAK_EN
  logic [KW-1:0]        brk_cnt_q, brk_cnt_d;
  logic                 brk_pend_q, brk_pend_d;
`endif

  logic                 wr, pop, bit_end, brk_req;
  logic [DATA_BITS-1:0] head;
  logic [DIV_WIDTH-1:0] div_eff;

  assign wr      = in_valid && in_ready_q;
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (baud_q == div_q - DIV_WIDTH'(1));
  assign div_eff = (clk_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : clk_div;
`ifdef UART_TX_BREAK_EN
  assign brk_req = send_break || brk_pend_q;
`else
  assign brk_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    div_d   = div_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pop     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d  = brk_cnt_q;
    brk_pend_d = brk_pend_q;
    if (send_break && (state_q != S_IDLE) && (state_q != S_BREAK))
      brk_pend_d = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
`ifdef UART_TX_BREAK_EN
        if (brk_req) begin
          state_d    = S_BREAK;
          div_d      = div_eff;
          brk_cnt_d  = '0;
          brk_pend_d = 1'b0;
        end else
`endif
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (PARITY == 1) ? ~(^head) : ^head;
          div_d   = div_eff;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else baud_d = baud_q + DIV_WIDTH'(1);
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else bit_d = bit_q + BW'(1);
        end else baud_d = baud_q + DIV_WIDTH'(1);
      end
      S_PAR: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else baud_d = baud_q + DIV_WIDTH'(1);
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next start bit; a pending break waits for IDLE.
            if ((count_q != '0) && !brk_req) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (PARITY == 1) ? ~(^head) : ^head;
              div_d   = div_eff;
              state_d = S_START;
            end else state_d = S_IDLE;
          end else bit_d = bit_q + BW'(1);
        end else baud_d = baud_q + DIV_WIDTH'(1);
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (bit_end) begin
          baud_d = '0;
          if (brk_cnt_q == KW'(BRK_BITS - 1)) begin
            if (!send_break) state_d = S_BRKSTP;
          end else brk_cnt_d = brk_cnt_q + KW'(1);
        end else baud_d = baud_q + DIV_WIDTH'(1);
      end
      S_BRKSTP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else baud_d = baud_q + DIV_WIDTH'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d   = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + LW'(wr) - LW'(pop);
    in_ready_d = (count_d != LW'(FIFO_DEPTH));
    busy_d     = (state_d != S_IDLE) || (count_d != '0);

    case (state_q)
      S_START: out_d = 1'b0;
      S_DATA:  out_d = shift_q[0];
      S_PAR:   out_d = par_q;
`ifdef UART_TX_BREAK_EN
      S_BREAK: out_d = 1'b0;
`endif
      default: out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      out_q      <= 1'b1;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      div_q      <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= '0;
      brk_pend_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      div_q      <= div_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= brk_cnt_d;
      brk_pend_q <= brk_pend_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign fifo_level = count_q;
  assign busy       = busy_q;
  assign out        = out_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default instance plus an even-parity, two-stop-bit instance.
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_valid, in_valid2;
  logic [7:0]  in_data, in_data2;
  logic [15:0] clk_div, clk_div2;
  logic        in_ready, in_ready2, busy, busy2, out, out2;
  logic [2:0]  fifo_level, fifo_level2;
`ifdef UART_TX_BREAK_EN
  logic        send_break;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clk_div(clk_div), .fifo_level(fifo_level), .busy(busy),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .out(out)
  );

  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) dut_p (
    .clk(clk), .n_reset(n_reset), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .clk_div(clk_div2), .fifo_level(fifo_level2), .busy(busy2),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .out(out2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level of bit slot idx in a default 8N1 frame carrying w.
  function automatic logic fbit(input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    return 1'b1;
  endfunction

  logic [7:0]  words [6];
  logic [11:0] pbits;
  int          wi;
  logic        acc;

  initial begin
    n_reset = 1'b0; in_valid = 1'b0; in_data = '0; in_valid2 = 1'b0; in_data2 = '0;
    clk_div = 16'd4; clk_div2 = 16'd3;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_out", out, 1); chk("rst_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0); chk("rst_busy", busy, 0);
    #2 n_reset = 1'b1;
    tick();

    // 0xA5, div 4
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("a5_busy_rise", busy, 1); chk("a5_level1", fifo_level, 1); chk("a5_out_n", out, 1);
    tick();
    chk("a5_out_n1", out, 1); chk("a5_level0", fifo_level, 0);
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("a5_out", out, fbit(8'hA5, c / 4));
      chk("a5_busy", busy, (c < 39) ? 1 : 0);
    end
    tick();
    chk("a5_idle_out", out, 1); chk("a5_idle_busy", busy, 0);

    // even parity, 2 stop bits, div 3, 0x07
    pbits = 12'b1110_0000_1110;
    in_valid2 = 1'b1; in_data2 = 8'h07;
    tick();
    in_valid2 = 1'b0;
    tick();
    chk("p_out_n1", out2, 1);
    for (int c = 0; c < 36; c++) begin
      tick();
      chk("p_out", out2, pbits[c / 3]);
      chk("p_busy", busy2, (c < 35) ? 1 : 0);
    end
    tick();
    chk("p_idle_out", out2, 1); chk("p_idle_busy", busy2, 0);

    // six words with in_valid held, depth 4
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
    wi = 0;
    for (int t = 0; t < 250; t++) begin
      in_valid = (wi < 6);
      if (wi < 6) in_data = words[wi];
      acc = in_valid && in_ready;
      tick();
      if (acc) wi++;
      if (t == 3) chk("ff_ready_t3", in_ready, 1);
      if (t == 4) begin
        chk("ff_accepted5", wi, 5); chk("ff_ready_low", in_ready, 0); chk("ff_level4", fifo_level, 4);
      end
      if (t >= 2 && t < 242) chk("ff_out", out, fbit(words[(t - 2) / 40], ((t - 2) % 40) / 4));
    end
    in_valid = 1'b0;
    chk("ff_all_written", wi, 6); chk("ff_busy_end", busy, 0); chk("ff_level_end", fifo_level, 0);

    // divisor change mid-frame
    for (int t = 0; t < 130; t++) begin
      in_valid = (t < 2);
      in_data  = (t == 0) ? 8'h3C : 8'hC3;
      if (t == 10) clk_div = 16'd8;
      tick();
      if (t >= 2 && t < 42)        chk("dv_out4", out, fbit(8'h3C, (t - 2) / 4));
      else if (t >= 42 && t < 122) chk("dv_out8", out, fbit(8'hC3, (t - 42) / 8));
      else if (t >= 122)           chk("dv_idle", out, 1);
    end
    in_valid = 1'b0;
    chk("dv_busy_end", busy, 0);
    clk_div = 16'd4;

    // async reset mid-DATA with a word still queued
    for (int t = 0; t < 13; t++) begin
      in_valid = (t < 2);
      in_data  = (t == 0) ? 8'h5A : 8'hF0;
      tick();
    end
    in_valid = 1'b0;
    chk("rs_pre_busy", busy, 1); chk("rs_pre_level", fifo_level, 1);
    #2 n_reset = 1'b0;
    #1;
    chk("rs_out", out, 1); chk("rs_level", fifo_level, 0);
    chk("rs_ready", in_ready, 1); chk("rs_busy", busy, 0);
    tick();
    #3 n_reset = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("rs_quiet", out, 1);
    end
    chk("rs_busy_after", busy, 0); chk("rs_level_after", fifo_level, 0);

`ifdef UART_TX_BREAK_EN
    // one-cycle break pulse in IDLE, word queued on the same edge
    clk_div = 16'd2;
    send_break = 1'b1; in_valid = 1'b1; in_data = 8'h81;
    tick();
    send_break = 1'b0; in_valid = 1'b0;
    chk("bk_level", fifo_level, 1);
    for (int c = 1; c <= 48; c++) begin
      tick();
      if (c <= 40)      chk("bk_low", out, 0);
      else if (c <= 43) chk("bk_mark", out, 1);
      else              chk("bk_start", out, 0);
    end
    clk_div = 16'd4;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
